// File: rtl/ir_transmitter.sv
// Pulse-width serializer: sends Din MSB first as low/data/high symbols plus a terminator '1' symbol.
// Latency: Dout/Busy change one cycle after Send is accepted; only Send is a request, and it is ignored while Busy.
module ir_transmitter #(
   parameter int Width         = 30,
   parameter int QuarterCycles = 27
) (
   input  logic             Clock,
   input  logic             Tx_Reset,
   input  logic [Width-1:0] Din,
   input  logic             Send,
   output logic             Dout,
   output logic             Busy,
   output logic             Done
);

   localparam int PW = $clog2(2 * QuarterCycles);
   localparam int SW = $clog2(Width + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOW  = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] HIGH = 2'd3;

   localparam logic [PW-1:0] Q_LAST   = PW'(QuarterCycles - 1);
   localparam logic [PW-1:0] D_LAST   = PW'(2 * QuarterCycles - 1);
   localparam logic [SW-1:0] SYM_LAST = SW'(Width);

   logic [1:0]       state;
   logic [Width-1:0] shreg;
   logic [SW-1:0]    sym_cnt;
   logic [PW-1:0]    phase_cnt;

   always_ff @(posedge Clock) begin
      if (Tx_Reset) begin
         state     <= IDLE;
         shreg     <= '0;
         sym_cnt   <= '0;
         phase_cnt <= '0;
         Dout      <= 1'b1;
         Busy      <= 1'b0;
         Done      <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Send) begin
                  shreg     <= Din;
                  sym_cnt   <= '0;
                  phase_cnt <= '0;
                  Dout      <= 1'b0;
                  Busy      <= 1'b1;
                  state     <= LOW;
               end
            end
            LOW: begin
               if (phase_cnt == Q_LAST) begin
                  phase_cnt <= '0;
                  // symbol index Width is the terminator, always sent as a '1'
                  Dout      <= (sym_cnt == SYM_LAST) ? 1'b1 : shreg[Width-1];
                  shreg     <= {shreg[Width-2:0], 1'b0};
                  state     <= DATA;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            DATA: begin
               if (phase_cnt == D_LAST) begin
                  phase_cnt <= '0;
                  Dout      <= 1'b1;
                  state     <= HIGH;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            HIGH: begin
               if (phase_cnt == Q_LAST) begin
                  phase_cnt <= '0;
                  if (sym_cnt != SYM_LAST) begin
                     sym_cnt <= sym_cnt + 1'b1;
                     Dout    <= 1'b0;
                     state   <= LOW;
                  end else begin
                     // Busy drops with Done so a Send in the Done cycle starts the next frame at once
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_transmitter.sv
// Directed bench for ir_transmitter: cycle-indexed spot vectors plus per-symbol width decoding of captured frames.
module tb_ir_transmitter;

   localparam int W      = 30;
   localparam int Q      = 27;
   localparam int SYM    = 4 * Q;
   localparam int FRAME  = (W + 1) * SYM;
   localparam int HMAX   = 8192;

   logic          Clock = 1'b0;
   logic          Tx_Reset = 1'b1;
   logic [W-1:0]  Din = '0;
   logic          Send = 1'b0;
   logic          Dout, Busy, Done;

   int vectors = 0;
   int miscompares = 0;

   logic hist_dout [HMAX];
   logic hist_busy [HMAX];
   logic hist_done [HMAX];

   typedef struct {
      int   idx;
      logic dout;
      logic busy;
      logic done;
   } vec_t;

   vec_t vecs [15];

   ir_transmitter #(.Width(W), .QuarterCycles(Q)) dut (
      .Clock    (Clock),
      .Tx_Reset (Tx_Reset),
      .Din      (Din),
      .Send     (Send),
      .Dout     (Dout),
      .Busy     (Busy),
      .Done     (Done)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Sends one request; on return the next negedge is cycle k+1 of the frame.
   task automatic start_frame(input logic [W-1:0] word);
      @(posedge Clock);
      #1;
      Din  = word;
      Send = 1'b1;
      @(posedge Clock);
      #1;
      Send = 1'b0;
   endtask

   // Records n cycles; optionally pulses Send with another word at two cycle indices.
   task automatic record(input int n, input int inj_a, input int inj_b, input logic [W-1:0] inj_din);
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         hist_dout[i] = Dout;
         hist_busy[i] = Busy;
         hist_done[i] = Done;
         if (i == inj_a || i == inj_b) begin
            Send = 1'b1;
            Din  = inj_din;
         end else begin
            Send = 1'b0;
         end
      end
   endtask

   // Decodes the frame starting at hist[base] by measuring each symbol's low width.
   task automatic check_frame(input int base, input logic [W-1:0] exp_word, input string tag);
      logic [W-1:0] got_word;
      int busy_cnt;
      int done_cnt;
      got_word = '0;
      for (int n = 0; n <= W; n++) begin
         int  lo;
         int  hi;
         int  exp_lo;
         logic b;
         lo = 0;
         hi = 0;
         while (lo < SYM && hist_dout[base + n * SYM + lo] == 1'b0) lo++;
         for (int j = lo; j < SYM; j++) if (hist_dout[base + n * SYM + j] == 1'b1) hi++;
         b      = (n < W) ? exp_word[W-1-n] : 1'b1;
         exp_lo = b ? Q : 3 * Q;
         check($sformatf("%s sym%0d low", tag, n), lo, exp_lo);
         check($sformatf("%s sym%0d high", tag, n), hi, SYM - exp_lo);
         if (n < W) got_word = {got_word[W-2:0], (lo == Q)};
      end
      check({tag, " word"}, int'(got_word), int'(exp_word));
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (hist_busy[base + i]) busy_cnt++;
         if (hist_done[base + i]) done_cnt++;
      end
      check({tag, " busy cycles"}, busy_cnt, FRAME);
      check({tag, " done inside frame"}, done_cnt, 0);
      check({tag, " done after frame"}, int'(hist_done[base + FRAME]), 1);
      check({tag, " busy at done"}, int'(hist_busy[base + FRAME]), 0);
      check({tag, " dout at done"}, int'(hist_dout[base + FRAME]), 1);
   endtask

   initial begin
      int dcnt;

      // Spot vectors for Din=30'h2DB6DB6D, indexed from cycle k+1.
      vecs[0]  = '{0,    1'b0, 1'b1, 1'b0};
      vecs[1]  = '{26,   1'b0, 1'b1, 1'b0};
      vecs[2]  = '{27,   1'b1, 1'b1, 1'b0};
      vecs[3]  = '{107,  1'b1, 1'b1, 1'b0};
      vecs[4]  = '{108,  1'b0, 1'b1, 1'b0};
      vecs[5]  = '{135,  1'b0, 1'b1, 1'b0};
      vecs[6]  = '{188,  1'b0, 1'b1, 1'b0};
      vecs[7]  = '{189,  1'b1, 1'b1, 1'b0};
      vecs[8]  = '{215,  1'b1, 1'b1, 1'b0};
      vecs[9]  = '{216,  1'b0, 1'b1, 1'b0};
      vecs[10] = '{3240, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{3267, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{3347, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{3348, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{3349, 1'b1, 1'b0, 1'b0};

      // Reset held with Send high: idle outputs, no frame.
      Tx_Reset = 1'b1;
      Send     = 1'b1;
      Din      = 30'h2AAAAAAA;
      for (int i = 0; i < 20; i++) begin
         @(posedge Clock);
         @(negedge Clock);
         check($sformatf("reset dout c%0d", i), int'(Dout), 1);
         check($sformatf("reset busy c%0d", i), int'(Busy), 0);
         check($sformatf("reset done c%0d", i), int'(Done), 0);
      end
      @(posedge Clock);
      #1;
      Tx_Reset = 1'b0;
      Send     = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check("idle dout", int'(Dout), 1);
      check("idle busy", int'(Busy), 0);

      // Single frame with spot vectors and full decode.
      start_frame(30'h2DB6DB6D);
      record(FRAME + 10, -1, -1, '0);
      foreach (vecs[v]) begin
         check($sformatf("vec%0d dout", v), int'(hist_dout[vecs[v].idx]), int'(vecs[v].dout));
         check($sformatf("vec%0d busy", v), int'(hist_busy[vecs[v].idx]), int'(vecs[v].busy));
         check($sformatf("vec%0d done", v), int'(hist_done[vecs[v].idx]), int'(vecs[v].done));
      end
      check_frame(0, 30'h2DB6DB6D, "f1");

      // Send re-pulsed mid-frame with a different word must not disturb the frame.
      start_frame(30'h2DB6DB6D);
      record(FRAME + 40, 100, 2000, 30'h15555555);
      check_frame(0, 30'h2DB6DB6D, "midsend");
      dcnt = 0;
      for (int i = 0; i < FRAME + 40; i++) if (hist_done[i]) dcnt++;
      check("midsend done count", dcnt, 1);

      // Back-to-back: Send held high; second word taken in the Done cycle.
      @(posedge Clock);
      #1;
      Din  = 30'h3FFFFFFF;
      Send = 1'b1;
      @(posedge Clock);
      for (int i = 0; i < 2 * FRAME + 20; i++) begin
         @(negedge Clock);
         hist_dout[i] = Dout;
         hist_busy[i] = Busy;
         hist_done[i] = Done;
         if (i == 10) Din = 30'h00000000;
         if (i == FRAME + 100) Send = 1'b0;
      end
      check_frame(0, 30'h3FFFFFFF, "b2b1");
      check("b2b gap dout", int'(hist_dout[FRAME + 1]), 0);
      check("b2b gap busy", int'(hist_busy[FRAME + 1]), 1);
      check_frame(FRAME + 1, 30'h00000000, "b2b2");

      // Reset at cycle 500 of a frame aborts it without Done.
      start_frame(30'h2DB6DB6D);
      for (int i = 0; i < 500; i++) @(negedge Clock);
      Tx_Reset = 1'b1;
      @(negedge Clock);
      check("abort dout", int'(Dout), 1);
      check("abort busy", int'(Busy), 0);
      check("abort done", int'(Done), 0);
      Tx_Reset = 1'b0;
      dcnt = 0;
      for (int i = 0; i < FRAME + 20; i++) begin
         @(negedge Clock);
         if (Done || Busy || !Dout) dcnt++;
      end
      check("abort stays idle", dcnt, 0);

      start_frame(30'h12345678);
      record(FRAME + 10, -1, -1, '0);
      check_frame(0, 30'h12345678, "post_abort");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
